// File: rtl/mem_arbiter_llsc_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_llsc_pkg
// Shared definitions for the two-master data RAM arbiter with LL/SC tracking:
// memory-op encodings, arbiter FSM states, SC result words and master ids.
// -----------------------------------------------------------------------------
package mem_arbiter_llsc_pkg;

    // Memory operation carried with each request (2'b11 behaves as normal).
    localparam logic [1:0] OP_NORMAL = 2'b00;
    localparam logic [1:0] OP_LL     = 2'b01;
    localparam logic [1:0] OP_SC     = 2'b10;

    // Arbiter FSM: one transaction in flight, IDLE -> ACCESS -> RESP -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Word returned to the master on an SC.
    localparam logic [31:0] SC_SUCCESS = 32'h0000_0001;
    localparam logic [31:0] SC_FAIL    = 32'h0000_0000;

    // Master identifiers.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Winner selection: a lone requester wins outright; on a tie the master
    // that did not win last time gets the port. Only meaningful when at
    // least one request is present.
    function automatic logic pick_winner(input logic req0,
                                         input logic req1,
                                         input logic last_grant);
        return (req0 && req1) ? ~last_grant : req1;
    endfunction

endpackage

// File: rtl/mem_arbiter_llsc_resv.sv
// -----------------------------------------------------------------------------
// mem_arbiter_llsc_resv (llsc_resv)
// One LL/SC reservation: a valid bit plus the reserved word address.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   set         : LL performed by the owner; reserve set_addr
//   set_addr    : word address (byte address bits [ADDR_W-1:2]) of the LL
//   clear       : drop the reservation (owner SC, or flush for master 0)
//   snoop_we    : the other master performed a write this cycle
//   snoop_addr  : word address of that write
//   llbit       : reservation valid
//   lladdr      : reserved word address
// Only the word part of the address is kept: the byte offset never takes
// part in any reservation comparison.
// -----------------------------------------------------------------------------
module mem_arbiter_llsc_resv #(
    parameter int WADDR_W = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set,
    input  logic [WADDR_W-1:0] set_addr,
    input  logic               clear,
    input  logic               snoop_we,
    input  logic [WADDR_W-1:0] snoop_addr,
    output logic               llbit,
    output logic [WADDR_W-1:0] lladdr
);

    logic w_snoop_hit;

    assign w_snoop_hit = snoop_we && (snoop_addr == lladdr);

    always_ff @(posedge clk) begin
        if (rst) begin
            llbit  <= 1'b0;
            lladdr <= '0;
        end else begin
            if (set) begin
                lladdr <= set_addr;
            end
            // clear outranks set so a flush landing on an LL leaves no
            // reservation behind.
            if (clear) begin
                llbit <= 1'b0;
            end else if (set) begin
                llbit <= 1'b1;
            end else if (w_snoop_hit) begin
                llbit <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_llsc.sv
// -----------------------------------------------------------------------------
// mem_arbiter_llsc
// Shares the single data RAM port between m0 (CPU MEM stage) and m1 (DMA or
// second core), and keeps one LL/SC reservation per master.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush_i           : exception/eret, drops the m0 reservation
//   mN_req/we/op      : request (held until ack), write flag, 00/01/10/11 op
//   mN_addr/sel/wdata : byte address, byte enables, write data
//   mN_ack            : one-cycle completion pulse
//   mN_rdata          : read data or SC result, valid with ack, held after
//   mem_ce/we/addr/sel/data_o : RAM request, active only in the ACCESS cycle
//   mem_data_i        : RAM read data (combinational read)
//   llbit0_o/llbit1_o : reservation valid flags
// A transaction takes IDLE (arbitrate) -> ACCESS (RAM cycle) -> RESP (ack).
// -----------------------------------------------------------------------------
import mem_arbiter_llsc_pkg::*;

module mem_arbiter_llsc #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [1:0]          m0_op,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W/8-1:0] m0_sel,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_ack,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [1:0]          m1_op,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W/8-1:0] m1_sel,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_ack,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                mem_ce,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_sel,
    output logic [DATA_W-1:0]   mem_data_o,
    input  logic [DATA_W-1:0]   mem_data_i,

    output logic                llbit0_o,
    output logic                llbit1_o
);

    localparam int WADDR_W = ADDR_W - 2;

    state_t                r_state;
    state_t                w_next_state;

    // Fields of the transaction in flight, latched when it is granted.
    logic                  r_last_grant;
    logic                  r_win;
    logic                  r_we;
    logic [1:0]            r_op;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W/8-1:0]   r_sel;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata0;
    logic [DATA_W-1:0]     r_rdata1;

    logic                  w_any_req;
    logic                  w_grant;
    logic                  w_access;
    logic                  w_is_ll;
    logic                  w_is_sc;
    logic                  w_win_llbit;
    logic [WADDR_W-1:0]    w_win_lladdr;
    logic                  w_sc_ok;
    logic                  w_do_ce;
    logic                  w_do_write;
    logic                  w_capture;
    logic [DATA_W-1:0]     w_access_rdata;

    logic                  w_llbit0;
    logic                  w_llbit1;
    logic [WADDR_W-1:0]    w_lladdr0;
    logic [WADDR_W-1:0]    w_lladdr1;

    // ------------------------------------------------------------------
    // Decode of the latched transaction
    // ------------------------------------------------------------------
    assign w_any_req = m0_req || m1_req;
    assign w_grant   = pick_winner(m0_req, m1_req, r_last_grant);

    // Reset is folded in so a transaction caught by rst in ACCESS never
    // reaches the RAM or the reservations.
    assign w_access  = (r_state == ST_ACCESS) && !rst;

    assign w_is_ll   = (r_op == OP_LL);
    assign w_is_sc   = (r_op == OP_SC);

    assign w_win_llbit  = (r_win == M1) ? w_llbit1  : w_llbit0;
    assign w_win_lladdr = (r_win == M1) ? w_lladdr1 : w_lladdr0;

    assign w_sc_ok    = w_is_sc && w_win_llbit &&
                        (r_addr[ADDR_W-1:2] == w_win_lladdr);

    // A failed SC is dropped entirely: no RAM cycle at all.
    assign w_do_ce    = !(w_is_sc && !w_sc_ok);
    assign w_do_write = w_is_sc ? w_sc_ok : (!w_is_ll && r_we);

    // Normal writes leave the master's rdata register untouched.
    assign w_capture  = w_is_sc || w_is_ll || !r_we;

    assign w_access_rdata = w_is_sc ? (w_sc_ok ? DATA_W'(SC_SUCCESS)
                                               : DATA_W'(SC_FAIL))
                                    : mem_data_i;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        w_next_state = r_state;
        mem_ce       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_sel      = '0;
        mem_data_o   = '0;
        m0_ack       = 1'b0;
        m1_ack       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_next_state = ST_RESP;
                if (w_access && w_do_ce) begin
                    mem_ce     = 1'b1;
                    mem_we     = w_do_write;
                    mem_addr   = r_addr;
                    mem_sel    = r_sel;
                    mem_data_o = w_do_write ? r_wdata : '0;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
                if (!rst) begin
                    m0_ack = (r_win == M0);
                    m1_ack = (r_win == M1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction latch and per-master read data
    // ------------------------------------------------------------------
    // NOTE: these are plain registers, not a memory array, and are reset
    // because mN_rdata must read 0 after reset; an inferred RAM would be
    // left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= M1;   // m0 wins the first tie after reset
            r_win        <= M0;
            r_we         <= 1'b0;
            r_op         <= OP_NORMAL;
            r_addr       <= '0;
            r_sel        <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_win        <= w_grant;
                r_last_grant <= w_grant;
                r_we         <= (w_grant == M1) ? m1_we    : m0_we;
                r_op         <= (w_grant == M1) ? m1_op    : m0_op;
                r_addr       <= (w_grant == M1) ? m1_addr  : m0_addr;
                r_sel        <= (w_grant == M1) ? m1_sel   : m0_sel;
                r_wdata      <= (w_grant == M1) ? m1_wdata : m0_wdata;
            end
            if (w_access && w_capture) begin
                if (r_win == M1) begin
                    r_rdata1 <= w_access_rdata;
                end else begin
                    r_rdata0 <= w_access_rdata;
                end
            end
        end
    end

    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;

    // ------------------------------------------------------------------
    // Reservations. Each master's LL sets its own; its SC clears it; a
    // write performed by the other master to the same word clears it.
    // ------------------------------------------------------------------
    mem_arbiter_llsc_resv #(
        .WADDR_W (WADDR_W)
    ) u_resv0 (
        .clk        (clk),
        .rst        (rst),
        .set        (w_access && (r_win == M0) && w_is_ll),
        .set_addr   (r_addr[ADDR_W-1:2]),
        .clear      (flush_i || (w_access && (r_win == M0) && w_is_sc)),
        .snoop_we   (w_access && (r_win == M1) && w_do_write),
        .snoop_addr (r_addr[ADDR_W-1:2]),
        .llbit      (w_llbit0),
        .lladdr     (w_lladdr0)
    );

    mem_arbiter_llsc_resv #(
        .WADDR_W (WADDR_W)
    ) u_resv1 (
        .clk        (clk),
        .rst        (rst),
        .set        (w_access && (r_win == M1) && w_is_ll),
        .set_addr   (r_addr[ADDR_W-1:2]),
        .clear      (w_access && (r_win == M1) && w_is_sc),
        .snoop_we   (w_access && (r_win == M0) && w_do_write),
        .snoop_addr (r_addr[ADDR_W-1:2]),
        .llbit      (w_llbit1),
        .lladdr     (w_lladdr1)
    );

    assign llbit0_o = w_llbit0;
    assign llbit1_o = w_llbit1;

endmodule
